// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage iterative divider: FSM states and the
// decoder op codes that drive start/signed_div.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock,
// result = {remainder, quotient}; stalls the pipeline while working.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_div,
  input  logic                 start,
  input  logic                 annul,
  output logic                 stall_req,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready
);

  localparam int CW = $clog2(WIDTH);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic               trial_neg;
  logic [WIDTH-1:0]   rem_next, dvd_next;

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign a_mag = (signed_div && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_div && b[WIDTH-1]) ? -b : b;

  // Extra top bit on the trial difference acts as the borrow / sign.
  assign shifted   = {rem_q, dvd_q[WIDTH-1]};
  assign trial     = {1'b0, shifted} - {2'b00, dvs_q};
  assign trial_neg = trial[WIDTH+1];
  assign rem_next  = trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign dvd_next  = {dvd_q[WIDTH-2:0], ~trial_neg};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    case (state_q)
      DIV_IDLE: begin
        if (start && !annul) begin
          if (b != '0) begin
            state_d = DIV_BUSY;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            count_d = '0;
            negq_d  = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            negr_d  = signed_div & a[WIDTH-1];
          end else begin
            state_d = DIV_ZERO;
          end
        end
      end
      DIV_ZERO: begin
        result_d = '0;
        state_d  = DIV_DONE;
      end
      DIV_BUSY: begin
        rem_d   = rem_next;
        dvd_d   = dvd_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          result_d = {(negr_q ? -rem_next : rem_next),
                      (negq_q ? -dvd_next : dvd_next)};
          state_d  = DIV_DONE;
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    // A flush wins over everything, including the final result write.
    if (annul) begin
      state_d  = DIV_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign result    = result_q;
  assign ready     = (state_q == DIV_DONE);
  assign stall_req = ~rst & ~annul &
                     (((state_q == DIV_IDLE) & start) |
                      (state_q == DIV_BUSY) |
                      (state_q == DIV_ZERO));

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit signed/unsigned divider that sits beside alu in the EX stage. It handles the DIV/DIVU ops that alu does not.
- Consumes the same EX operands (rs value as a, rt value as b). Produces {hi, lo} = {remainder, quotient} for the HILO write in the EX/MEM register.
- Stalls the pipeline while busy.
- A restoring shift-subtract loop, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand width; result width is 2*WIDTH. Only 32 is verified.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a  in  WIDTH  dividend (rs)
- b  in  WIDTH  divisor (rt)
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- start  in  1  request; held high by EX while the instruction is in EX
- annul  in  1  flush/exception; aborts the operation
- stall_req  out  1  to hazard unit; freezes PC, IF/ID, ID/EX while high
- result  out  2*WIDTH  {remainder[63:32], quotient[31:0]}
- ready  out  1  one-cycle pulse; result is valid this cycle

Behaviour:
- Reset (async, rst=1): state=IDLE, result=0, ready=0, counter=0, internal regs=0. stall_req=0.
- States: IDLE, DIV_ZERO, BUSY, DONE. Encodings live in defines.vh.
- IDLE:
  - start=1, annul=0, b!=0: latch |a|, |b| (magnitude only if signed_div), neg_q=signed_div&(a[31]^b[31]), neg_r=signed_div&a[31]. Clear partial remainder. counter=0. Go to BUSY.
  - start=1, annul=0, b==0: go to DIV_ZERO.
  - Otherwise stay in IDLE.
- DIV_ZERO: result<=64'h0. Go to DONE. MIPS leaves the result undefined; the team fixes it to 0.
- BUSY:
  - Each cycle: shift {rem,dividend} left by 1 and trial-subtract divisor from the upper 33 bits. If non-negative, keep the difference and set q bit=1. counter++.
  - When counter==31 completes: result <= {neg_r ? -rem : rem, neg_q ? -q : q}. Go to DONE.
- DONE: ready=1 for exactly this cycle. Go to IDLE unconditionally; start is ignored in DONE.
- stall_req (combinational) = (state==IDLE & start & ~annul) | state==BUSY | state==DIV_ZERO. It is 0 in DONE so the instruction advances with result.
- Latency: start seen in IDLE at cycle 0 → BUSY for cycles 1..32 → ready at cycle 33. Divide-by-zero: ready at cycle 2.
- annul=1 in any state:
  - Next state is IDLE; ready stays 0 in the following cycle.
  - result is not updated. If annul arrives in the same cycle as the BUSY→DONE update, the update is suppressed.
  - stall_req drops combinationally the same cycle.
- Operand changes after acceptance are ignored; only latched values are used.
- result holds its last value until the next completed division.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient=0x80000000, remainder=0. No trap.
- Remainder sign follows the dividend; quotient truncates toward zero.

Decomposition:
- defines.vh carries:
  - DIV state encodings: DIV_IDLE, DIV_BUSY, DIV_ZERO, DIV_DONE.
  - EXE_DIV_OP and EXE_DIVU_OP codes, so the decoder asserts start and signed_div.
- No sub-module. The 33-bit trial subtract stays inline; the whole block is one FSM plus datapath, about 150 lines.

Test Plan:
- DIVU a=100, b=7, start held → stall_req high cycles 0..32; ready at cycle 33 with result={32'd2, 32'd14}.
- DIV a=-7 (0xFFFFFFF9), b=2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Same inputs with DIVU → q=0x7FFFFFFC, r=1.
- DIV a=0x80000000, b=0xFFFFFFFF → q=0x80000000, r=0, ready at cycle 33. DIVU a=0xFFFFFFFF, b=1 → q=0xFFFFFFFF, r=0.
- b=0 (either mode) → ready at cycle 2, result=64'h0, stall_req high only cycles 0..1.
- annul pulsed at BUSY cycle 10 → state IDLE next cycle, stall_req low, no ready pulse, result keeps prior value. A new start then completes normally.
- rst asserted mid-BUSY, asynchronously between edges → outputs clear immediately: result=0, ready=0, stall_req=0. Back-to-back starts after DONE each give correct independent results.
